lcd_responder: RTL and testbench
================================

Name: lcd_responder

Overview:
- Cycle-level model of an HD44780-style character LCD: the device end of the memory-mapped LCD bus the CPU top drives (lcd_data, lcd_ctrl, lcd_enable).
- Latches transfers on the falling edge of lcd_enable and executes a subset of commands against an internal display RAM (DDRAM).
- Models the busy time and answers busy-flag and data reads.
- Exposes a character strobe and a debug read port so benches can check displayed text without $write.

Parameters:
- DEPTH, 80, number of DDRAM cells (address range 0..DEPTH-1, max 128).
- BUSY_CYCLES, 4, clk cycles busy after any accepted command or data transfer.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- lcd_data  input  8  bus data from host.
- lcd_ctrl  input  2  bit1 = RS (1 data, 0 instruction), bit0 = RW (1 read, 0 write).
- lcd_enable  input  1  strobe; transfer commits on falling edge.
- lcd_rdata  output  8  read data toward host.
- busy  output  1  device busy flag.
- cursor_addr  output  7  current address counter (AC).
- char_valid  output  1  one-cycle pulse per accepted data write.
- char_data  output  8  character written (valid with char_valid).
- char_addr  output  7  DDRAM address written (valid with char_valid).
- overrun  output  1  sticky: transfer attempted while busy.
- dbg_addr  input  7  debug DDRAM read address.
- dbg_data  output  8  DDRAM[dbg_addr], combinational; 0 if dbg_addr >= DEPTH.

Behaviour:
- Clock and reset: clk and rst_n; rst_n is asynchronous, active-low. All inputs are synchronous to clk; no synchroniser.
- Edge detection: en_q registers lcd_enable. fall = en_q & ~lcd_enable. lcd_data and lcd_ctrl are sampled in the fall cycle; effects are visible after the next clk edge.
- Reset values: en_q=0, AC=0, I/D=1, char_valid=0, char_data=0, char_addr=0, overrun=0, state=CLEAR, sweep index=0, busy=1.
- State machine, states IDLE / CLEAR / BUSY:
  - CLEAR: writes 0x20 to DDRAM[idx], one cell per cycle, idx 0..DEPTH-1. After the last cell, go to BUSY with counter=BUSY_CYCLES, or to IDLE if BUSY_CYCLES=0.
  - BUSY: decrements the counter; goes to IDLE on the cycle it reaches 0.
  - busy=1 in CLEAR and BUSY.
- Transfers on fall while IDLE:
  - ctrl=10 (data write): DDRAM[AC] <= lcd_data; pulse char_valid with char_data=lcd_data, char_addr=AC; step AC; enter BUSY.
  - ctrl=11 (data read): step AC; enter BUSY.
  - ctrl=01 (busy/AC read): no state effect; never sets overrun; never busy.
  - ctrl=00, instruction decode on lcd_data:
    - 0x01 clear: AC=0, I/D=1, enter CLEAR with idx=0.
    - 0x02/0x03 home: AC=0, enter BUSY.
    - 0x04..0x07 entry mode: I/D=lcd_data[1] (shift bit ignored), enter BUSY.
    - 0x80..0xFF set address: AC=lcd_data[6:0], or 0 if >= DEPTH; enter BUSY.
    - All other values: ignored, no busy.
- AC step: if I/D=1, AC+1 with wrap DEPTH-1 -> 0; if I/D=0, AC-1 with wrap 0 -> DEPTH-1.
- Transfers on fall while busy: any ctrl other than 01 is dropped with no DDRAM/AC/state change and sets overrun=1. overrun clears only on reset.
- lcd_rdata (combinational from registers):
  - lcd_enable=1, ctrl=01: {busy, AC}.
  - lcd_enable=1, ctrl=11: DDRAM[AC].
  - Otherwise: 0x00.
- BUSY_CYCLES=0: every accepted op except clear returns to IDLE immediately; busy stays 0.
- Reset asserted mid-operation: immediate return to reset values and restart of the CLEAR sweep.

Test Plan:
- Release reset, hold lcd_enable=0 -> busy=1 for exactly 80+4 cycles, then 0; dbg_data=0x20 for dbg_addr 0, 40, 79; cursor_addr=0.
- After idle, write ctrl=10, data 0x48 (enable 1 then 0), wait, then 0x69 -> char_valid pulses with (0x48,0), then (0x69,1); DDRAM[0]=0x48, DDRAM[1]=0x69; cursor_addr=2; busy high 4 cycles after each fall.
- Command 0xCF (set addr 79), write 0x41, then write 0x42 -> DDRAM[79]=0x41, DDRAM[0]=0x42 (wrap); then 0x04 (decrement), write 0x43 at AC=1 -> DDRAM[1]=0x43, cursor_addr=0.
- Second data write issued one cycle after the first fall (busy=1) -> DDRAM unchanged, no char_valid, overrun=1 and stays 1. Busy-flag read (ctrl=01) during busy -> lcd_rdata[7]=1, overrun not set by it.
- Set addr 0x05, then ctrl=11 with enable high -> lcd_rdata=DDRAM[5]; after fall cursor_addr=6. Command 0x01 -> busy 84 cycles, all cells 0x20, cursor_addr=0.
- Assert rst_n low mid-CLEAR at idx=30 -> outputs at reset values immediately; on release, the full 84-cycle busy sweep restarts.

Source files
------------

// File: rtl/lcd_responder_if.sv
// Host-side bus of the character LCD: write data, RS/RW control, enable strobe and read-back data.
interface lcd_responder_if;
  logic [7:0] lcd_data;
  logic [1:0] lcd_ctrl;
  logic       lcd_enable;
  logic [7:0] lcd_rdata;

  modport master (
    output lcd_data,
    output lcd_ctrl,
    output lcd_enable,
    input  lcd_rdata
  );

  modport slave (
    input  lcd_data,
    input  lcd_ctrl,
    input  lcd_enable,
    output lcd_rdata
  );
endinterface

// File: rtl/lcd_responder.sv
// Cycle-level HD44780-style LCD model: commits bus transfers on the falling edge of the enable
// strobe, runs a command subset against DDRAM and models busy time, busy-flag and data reads.
module lcd_responder #(
  parameter int unsigned DEPTH       = 80,
  parameter int unsigned BUSY_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  lcd_responder_if.slave   lcd_bus,
  output logic             busy_o,
  output logic [6:0]       cursor_addr_o,
  output logic             char_valid_o,
  output logic [7:0]       char_data_o,
  output logic [6:0]       char_addr_o,
  output logic             overrun_o,
  input  logic [6:0]       dbg_addr_i,
  output logic [7:0]       dbg_data_o
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CntW = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES + 1) : 1;
  localparam logic [6:0]      LastAddr = 7'(DEPTH - 1);
  localparam logic [CntW-1:0] BusyInit = CntW'(BUSY_CYCLES);

  typedef enum logic [1:0] {StIdle, StClear, StBusy} state_e;

  // With no busy time configured, accepted ops fall straight back to idle.
  localparam state_e StAfterOp = (BUSY_CYCLES == 0) ? StIdle : StBusy;

  state_e          state_q, state_d;
  logic            en_q;
  logic [6:0]      ac_q, ac_d;
  logic [6:0]      idx_q, idx_d;
  logic            id_q, id_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            char_valid_q, char_valid_d;
  logic [7:0]      char_data_q, char_data_d;
  logic [6:0]      char_addr_q, char_addr_d;
  logic            overrun_q, overrun_d;

  logic [7:0] mem_q [DEPTH];
  logic       mem_we;
  logic [6:0] mem_waddr;
  logic [7:0] mem_wdata;

  logic       fall;
  logic       busy;
  logic       go_busy;
  logic [6:0] ac_step;
  logic [7:0] din;

  assign din  = lcd_bus.lcd_data;
  assign fall = en_q & ~lcd_bus.lcd_enable;
  assign busy = (state_q != StIdle);

  always_comb begin
    if (id_q) begin
      ac_step = (ac_q == LastAddr) ? 7'd0 : ac_q + 7'd1;
    end else begin
      ac_step = (ac_q == 7'd0) ? LastAddr : ac_q - 7'd1;
    end
  end

  always_comb begin
    state_d      = state_q;
    ac_d         = ac_q;
    id_d         = id_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    char_valid_d = 1'b0;
    char_data_d  = char_data_q;
    char_addr_d  = char_addr_q;
    overrun_d    = overrun_q;
    mem_we       = 1'b0;
    mem_waddr    = ac_q;
    mem_wdata    = din;
    go_busy      = 1'b0;

    unique case (state_q)
      StClear: begin
        mem_we    = 1'b1;
        mem_waddr = idx_q;
        mem_wdata = 8'h20;
        idx_d     = idx_q + 7'd1;
        if (idx_q == LastAddr) begin
          state_d = StAfterOp;
          cnt_d   = BusyInit;
        end
      end
      StBusy: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q <= CntW'(1)) state_d = StIdle;
      end
      default: ;
    endcase

    if (fall) begin
      if (busy) begin
        // Busy-flag reads are always legal; anything else is lost.
        if (lcd_bus.lcd_ctrl != 2'b01) overrun_d = 1'b1;
      end else begin
        unique case (lcd_bus.lcd_ctrl)
          2'b10: begin
            mem_we       = 1'b1;
            char_valid_d = 1'b1;
            char_data_d  = din;
            char_addr_d  = ac_q;
            ac_d         = ac_step;
            go_busy      = 1'b1;
          end
          2'b11: begin
            ac_d    = ac_step;
            go_busy = 1'b1;
          end
          2'b01: ;
          default: begin
            if (din == 8'h01) begin
              ac_d    = 7'd0;
              id_d    = 1'b1;
              idx_d   = 7'd0;
              state_d = StClear;
            end else if (din[7:1] == 7'h01) begin
              ac_d    = 7'd0;
              go_busy = 1'b1;
            end else if (din[7:2] == 6'h01) begin
              id_d    = din[1];
              go_busy = 1'b1;
            end else if (din[7]) begin
              ac_d    = (din[6:0] > LastAddr) ? 7'd0 : din[6:0];
              go_busy = 1'b1;
            end
          end
        endcase
      end
    end

    if (go_busy) begin
      state_d = StAfterOp;
      cnt_d   = BusyInit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StClear;
      en_q         <= 1'b0;
      ac_q         <= 7'd0;
      idx_q        <= 7'd0;
      id_q         <= 1'b1;
      cnt_q        <= '0;
      char_valid_q <= 1'b0;
      char_data_q  <= 8'h00;
      char_addr_q  <= 7'd0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      en_q         <= lcd_bus.lcd_enable;
      ac_q         <= ac_d;
      idx_q        <= idx_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
      char_valid_q <= char_valid_d;
      char_data_q  <= char_data_d;
      char_addr_q  <= char_addr_d;
      overrun_q    <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr[AW-1:0]] <= mem_wdata;
  end

  always_comb begin
    lcd_bus.lcd_rdata = 8'h00;
    if (lcd_bus.lcd_enable) begin
      if (lcd_bus.lcd_ctrl == 2'b01) begin
        lcd_bus.lcd_rdata = {busy, ac_q};
      end else if (lcd_bus.lcd_ctrl == 2'b11) begin
        lcd_bus.lcd_rdata = mem_q[ac_q[AW-1:0]];
      end
    end
  end

  assign dbg_data_o    = (dbg_addr_i <= LastAddr) ? mem_q[dbg_addr_i[AW-1:0]] : 8'h00;
  assign busy_o        = busy;
  assign cursor_addr_o = ac_q;
  assign char_valid_o  = char_valid_q;
  assign char_data_o   = char_data_q;
  assign char_addr_o   = char_addr_q;
  assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_lcd_responder.sv
// Bench for lcd_responder: directed scenarios plus random bus traffic, every cycle compared
// against a transaction-level LCD model (address counter, busy countdown, DDRAM array).
module tb_lcd_responder;

  localparam int Depth       = 80;
  localparam int BusyCycles  = 4;
  localparam int ClearCycles = Depth + BusyCycles;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lcd_responder_if bus ();

  logic       busy, char_valid, overrun;
  logic [6:0] cursor_addr, char_addr, dbg_addr;
  logic [7:0] char_data, dbg_data;

  lcd_responder #(
    .DEPTH      (Depth),
    .BUSY_CYCLES(BusyCycles)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lcd_bus      (bus),
    .busy_o       (busy),
    .cursor_addr_o(cursor_addr),
    .char_valid_o (char_valid),
    .char_data_o  (char_data),
    .char_addr_o  (char_addr),
    .overrun_o    (overrun),
    .dbg_addr_i   (dbg_addr),
    .dbg_data_o   (dbg_data)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] m_mem [Depth];
  int         m_ac;
  bit         m_id;
  bit         m_prev_en;
  bit         m_cv;
  int         m_cd;
  int         m_ca;
  bit         m_ovr;
  int         m_busy_left;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_ac        = 0;
    m_id        = 1'b1;
    m_prev_en   = 1'b0;
    m_cv        = 1'b0;
    m_cd        = 0;
    m_ca        = 0;
    m_ovr       = 1'b0;
    m_busy_left = ClearCycles;
    for (int i = 0; i < Depth; i++) m_mem[i] = 8'h20;
  endfunction

  function automatic void model_advance();
    m_ac = m_id ? (m_ac + 1) % Depth : (m_ac + Depth - 1) % Depth;
  endfunction

  // One clock edge with the given inputs held through the cycle.
  function automatic void model_step(input bit en, input logic [1:0] ctrl, input logic [7:0] data);
    bit fall;
    fall      = m_prev_en && !en;
    m_prev_en = en;
    m_cv      = 1'b0;
    if (!fall || m_busy_left > 0) begin
      if (fall && ctrl != 2'b01) m_ovr = 1'b1;
      if (m_busy_left > 0) m_busy_left--;
    end else begin
      case (ctrl)
        2'b10: begin
          m_mem[m_ac] = data;
          m_cv        = 1'b1;
          m_cd        = data;
          m_ca        = m_ac;
          model_advance();
          m_busy_left = BusyCycles;
        end
        2'b11: begin
          model_advance();
          m_busy_left = BusyCycles;
        end
        2'b00: begin
          if (data == 8'h01) begin
            m_ac        = 0;
            m_id        = 1'b1;
            m_busy_left = ClearCycles;
            for (int i = 0; i < Depth; i++) m_mem[i] = 8'h20;
          end else if (data == 8'h02 || data == 8'h03) begin
            m_ac        = 0;
            m_busy_left = BusyCycles;
          end else if (data >= 8'h04 && data <= 8'h07) begin
            m_id        = data[1];
            m_busy_left = BusyCycles;
          end else if (data >= 8'h80) begin
            m_ac        = (int'(data) - 128 < Depth) ? int'(data) - 128 : 0;
            m_busy_left = BusyCycles;
          end
        end
        default: ;
      endcase
    end
  endfunction

  task automatic cyc(input bit en, input logic [1:0] ctrl, input logic [7:0] data);
    logic [7:0] exp_rd;
    bit         sweep;
    bus.lcd_enable = en;
    bus.lcd_ctrl   = ctrl;
    bus.lcd_data   = data;
    dbg_addr       = 7'($urandom_range(0, 127));
    @(negedge clk);
    model_step(en, ctrl, data);
    sweep = m_busy_left > BusyCycles;
    check_eq("busy", busy, m_busy_left > 0);
    check_eq("cursor_addr", cursor_addr, m_ac);
    check_eq("char_valid", char_valid, m_cv);
    check_eq("char_data", char_data, m_cd);
    check_eq("char_addr", char_addr, m_ca);
    check_eq("overrun", overrun, m_ovr);
    exp_rd = 8'h00;
    if (en && ctrl == 2'b01) exp_rd = {(m_busy_left > 0) ? 1'b1 : 1'b0, 7'(m_ac)};
    if (en && ctrl == 2'b11) exp_rd = m_mem[m_ac];
    if (!(en && ctrl == 2'b11 && sweep)) check_eq("lcd_rdata", bus.lcd_rdata, exp_rd);
    if (!sweep) check_eq("dbg_data", dbg_data, (dbg_addr < Depth) ? m_mem[dbg_addr] : 8'h00);
  endtask

  task automatic xfer(input logic [1:0] ctrl, input logic [7:0] data, input int gap);
    cyc(1'b1, ctrl, data);
    cyc(1'b0, ctrl, data);
    for (int i = 0; i < gap; i++) cyc(1'b0, ctrl, data);
  endtask

  task automatic peek(input logic [6:0] a, input logic [7:0] exp, input string tag);
    dbg_addr = a;
    #1;
    check_eq(tag, dbg_data, exp);
  endtask

  task automatic check_reset_outputs();
    #1;
    check_eq("rst_busy", busy, 1);
    check_eq("rst_cursor", cursor_addr, 0);
    check_eq("rst_char_valid", char_valid, 0);
    check_eq("rst_char_data", char_data, 0);
    check_eq("rst_char_addr", char_addr, 0);
    check_eq("rst_overrun", overrun, 0);
  endtask

  initial begin
    logic [1:0] rc;
    logic [7:0] rd;
    bus.lcd_enable = 1'b0;
    bus.lcd_ctrl   = 2'b00;
    bus.lcd_data   = 8'h00;
    dbg_addr       = 7'd0;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (ClearCycles + 4) cyc(1'b0, 2'b00, 8'h00);
    peek(7'd0, 8'h20, "sweep_cell0");
    peek(7'd40, 8'h20, "sweep_cell40");
    peek(7'd79, 8'h20, "sweep_cell79");

    // Two plain character writes
    xfer(2'b10, 8'h48, 5);
    xfer(2'b10, 8'h69, 5);
    peek(7'd0, 8'h48, "write_cell0");
    peek(7'd1, 8'h69, "write_cell1");
    check_eq("cursor_after_writes", cursor_addr, 2);

    // Wrap at the top, then decrement mode
    xfer(2'b00, 8'hCF, 5);
    xfer(2'b10, 8'h41, 5);
    xfer(2'b10, 8'h42, 5);
    peek(7'd79, 8'h41, "wrap_cell79");
    peek(7'd0, 8'h42, "wrap_cell0");
    xfer(2'b00, 8'h04, 5);
    xfer(2'b10, 8'h43, 5);
    peek(7'd1, 8'h43, "dec_cell1");
    check_eq("cursor_after_dec", cursor_addr, 0);

    // Overrun, then a busy-flag read while busy
    xfer(2'b10, 8'h55, 0);
    xfer(2'b10, 8'h66, 5);
    check_eq("overrun_sticky", overrun, 1);
    xfer(2'b10, 8'h77, 0);
    xfer(2'b01, 8'h00, 5);

    // Data read, then a full clear
    xfer(2'b00, 8'h06, 5);
    xfer(2'b00, 8'h85, 5);
    xfer(2'b11, 8'h00, 5);
    check_eq("cursor_after_read", cursor_addr, 6);
    xfer(2'b00, 8'h01, ClearCycles + 2);
    peek(7'd0, 8'h20, "clear_cell0");
    peek(7'd79, 8'h20, "clear_cell79");
    peek(7'd100, 8'h00, "dbg_out_of_range");

    for (int n = 0; n < 300; n++) begin
      rc = 2'($urandom_range(0, 3));
      rd = 8'($urandom);
      if (rc == 2'b00) begin
        case ($urandom_range(0, 15))
          0:       rd = 8'h01;
          1, 2:    rd = 8'($urandom_range(2, 3));
          3, 4, 5: rd = 8'($urandom_range(4, 7));
          6, 7:    rd = 8'h00 | 8'($urandom_range(8, 127));
          default: rd = 8'h80 | 8'($urandom_range(0, 127));
        endcase
      end
      xfer(rc, rd, $urandom_range(0, 6));
    end

    // Reset in the middle of a clear sweep
    xfer(2'b00, 8'h01, 30);
    rst_n = 1'b0;
    bus.lcd_enable = 1'b0;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (ClearCycles + 4) cyc(1'b0, 2'b00, 8'h00);
    for (int n = 0; n < 20; n++) xfer(2'($urandom_range(1, 3)), 8'($urandom), $urandom_range(0, 5));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
